// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - 5x5 window feeder: buffers five image rows, replays column vectors
// Five line buffers in a ring; each window leaves as five back-to-back column beats.
module conv_window_feeder #(
  parameter int data_width = 16,
  parameter int img_w      = 28,
  parameter int img_h      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [data_width-1:0] d_out1,
  output logic [data_width-1:0] d_out2,
  output logic [data_width-1:0] d_out3,
  output logic [data_width-1:0] d_out4,
  output logic [data_width-1:0] d_out5,
  output logic                  out_valid,
  output logic                  frame_done
);

  localparam int cw = $clog2(img_w);
  localparam int rw = $clog2(img_h);
  localparam logic [cw-1:0] last_col   = cw'(img_w - 1);
  localparam logic [cw-1:0] last_win   = cw'(img_w - 5);
  localparam logic [rw-1:0] last_phase = rw'(img_h - 5);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, LOAD} state_t;

  state_t                state;
  logic [cw-1:0]         col;
  logic [cw-1:0]         win;
  logic [2:0]            beat;
  logic [rw-1:0]         row_cnt;
  logic [2:0]            oldest;
  logic [2:0]            fill_row;
  logic                  issuing;
  logic                  rd_v;
  logic                  rd_last;
  logic                  out_last;
  logic [data_width-1:0] mem [5][img_w];
  logic [data_width-1:0] rd_data [5];
  logic [data_width-1:0] out_r [5];
  logic                  accept;
  logic [2:0]            wr_slot;
  logic [cw-1:0]         rd_addr;

  assign accept  = pix_valid && pix_ready;
  assign wr_slot = (state == FILL) ? fill_row : oldest;
  assign rd_addr = win + cw'(beat);

  assign d_out1 = out_r[0];
  assign d_out2 = out_r[1];
  assign d_out3 = out_r[2];
  assign d_out4 = out_r[3];
  assign d_out5 = out_r[4];

  function automatic logic [2:0] rot(input logic [2:0] base, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, k};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Line buffers: written at the current column, all five read at the same column address.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (accept && wr_slot == 3'(k))
        mem[k][col] <= pix_in;
      rd_data[k] <= mem[k][rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      win        <= '0;
      beat       <= '0;
      row_cnt    <= '0;
      oldest     <= '0;
      fill_row   <= '0;
      issuing    <= 1'b0;
      rd_v       <= 1'b0;
      rd_last    <= 1'b0;
      out_last   <= 1'b0;
      pix_ready  <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 5; k++) out_r[k] <= '0;
    end else begin
      frame_done <= 1'b0;
      out_valid  <= rd_v;
      out_last   <= rd_last;
      rd_v       <= 1'b0;
      rd_last    <= 1'b0;
      // Output stage maps physical slots to window rows, oldest row on d_out1.
      if (rd_v)
        for (int k = 0; k < 5; k++) out_r[k] <= rd_data[rot(oldest, 3'(k))];

      case (state)
        IDLE: begin
          state     <= FILL;
          pix_ready <= 1'b1;
        end

        FILL: begin
          if (accept) begin
            if (col == last_col) begin
              col <= '0;
              if (fill_row == 3'd4) begin
                fill_row  <= '0;
                state     <= EMIT;
                pix_ready <= 1'b0;
                issuing   <= 1'b1;
              end else begin
                fill_row <= fill_row + 3'd1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            if (col == last_col) begin
              col       <= '0;
              oldest    <= (oldest == 3'd4) ? 3'd0 : oldest + 3'd1;
              state     <= EMIT;
              pix_ready <= 1'b0;
              issuing   <= 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        EMIT: begin
          if (issuing) begin
            rd_v    <= 1'b1;
            rd_last <= (win == last_win) && (beat == 3'd4);
            if (beat == 3'd4) begin
              beat <= '0;
              if (win == last_win) begin
                win     <= '0;
                issuing <= 1'b0;
              end else begin
                win <= win + 1'b1;
              end
            end else begin
              beat <= beat + 3'd1;
            end
          end else if (out_last) begin
            // Phase leaves the pipe on this edge: reopen the input as out_valid drops.
            pix_ready <= 1'b1;
            if (row_cnt == last_phase) begin
              row_cnt    <= '0;
              oldest     <= '0;
              frame_done <= 1'b1;
              state      <= FILL;
            end else begin
              row_cnt <= row_cnt + 1'b1;
              state   <= LOAD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
